// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a downstream 4-to-1 mux: steps sel through channels 0..3 and holds
// each for DWELL cycles, samples mux_out, and offers the 4-bit word over valid/ready.
// Define MUX_SCAN_PARITY_EN to add a registered even-parity output alongside data.
module mux_scan_sequencer #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] data,
    output logic       data_valid,
    input  logic       data_ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity_q, parity_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                    cnt_d   = 4'd0;
                    ch_d    = 2'd0;
                end
            end
            SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    shadow_d[ch_q] = mux_out;
                    cnt_d          = 4'd0;
                    if (ch_q == 2'd3) begin
                        // Word includes the bit being sampled on this same edge.
                        data_d  = {mux_out, shadow_q[2:0]};
                        valid_d = 1'b1;
                        ch_d    = 2'd0;
                        state_d = HOLD;
`ifdef MUX_SCAN_PARITY_EN
                        parity_d = ^{mux_out, shadow_q[2:0]};
`endif
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (data_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
                ch_d    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            ch_q     <= 2'd0;
            shadow_q <= 4'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // The channel register doubles as sel; it is parked at 0 outside SCAN.
    assign sel        = ch_q;
    assign busy       = busy_q;
    assign data       = data_q;
    assign data_valid = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    assign parity     = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: one instance with DWELL=2 and one with DWELL=1, each driven by a
// behavioural 4-to-1 mux model (mux_out = in[sel]).
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start_a = 1'b0, ready_a = 1'b0, mux_a;
    logic [3:0] in_a = 4'd0;
    logic [1:0] sel_a;
    logic       busy_a, dv_a;
    logic [3:0] data_a;

    logic       start_b = 1'b0, ready_b = 1'b1, mux_b;
    logic [3:0] in_b = 4'd0;
    logic [1:0] sel_b;
    logic       busy_b, dv_b;
    logic [3:0] data_b;

`ifdef MUX_SCAN_PARITY_EN
    logic       par_a, par_b;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mux_a = in_a[sel_a];
    assign mux_b = in_b[sel_b];

    mux_scan_sequencer #(.DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mux_out(mux_a), .sel(sel_a),
        .busy(busy_a), .data(data_a), .data_valid(dv_a), .data_ready(ready_a)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par_a)
`endif
    );

    mux_scan_sequencer #(.DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mux_out(mux_b), .sel(sel_b),
        .busy(busy_b), .data(data_b), .data_valid(dv_b), .data_ready(ready_b)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par_b)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, observed while rst_n is low.
        #12;
        check("rst_sel_a", {6'd0, sel_a}, 8'd0);
        check("rst_busy_a", {7'd0, busy_a}, 8'd0);
        check("rst_data_a", {4'd0, data_a}, 8'd0);
        check("rst_dv_a", {7'd0, dv_a}, 8'd0);
        check("rst_dv_b", {7'd0, dv_b}, 8'd0);
        #10 rst_n = 1'b1;
        tick();

        // DWELL=2 basic scan, in=1010: sel 0,0,1,1,2,2,3,3 then valid.
        in_a = 4'b1010;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_busy_after_start", {7'd0, busy_a}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a_sel_%0d", i), {6'd0, sel_a}, 8'(i / 2));
            check($sformatf("a_dv_low_%0d", i), {7'd0, dv_a}, 8'd0);
            if (i < 7) tick();
        end
        tick();
        check("a_dv_at_8", {7'd0, dv_a}, 8'd1);
        check("a_data_1010", {4'd0, data_a}, 8'b1010);
        check("a_sel_hold", {6'd0, sel_a}, 8'd0);
        check("a_busy_hold", {7'd0, busy_a}, 8'd1);
`ifdef MUX_SCAN_PARITY_EN
        check("a_parity_1010", {7'd0, par_a}, 8'd0);
`endif

        // Ready stalled for 10 cycles, start pulsed and input changed during HOLD.
        in_a = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            start_a = (i == 3);
            tick();
            check($sformatf("a_stall_dv_%0d", i), {7'd0, dv_a}, 8'd1);
            check($sformatf("a_stall_data_%0d", i), {4'd0, data_a}, 8'b1010);
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        start_a = 1'b1;  // start together with ready: accepted word only, no new scan
        tick();
        start_a = 1'b0;
        ready_a = 1'b0;
        check("a_accept_dv", {7'd0, dv_a}, 8'd0);
        check("a_accept_busy", {7'd0, busy_a}, 8'd0);
        check("a_idle_data_kept", {4'd0, data_a}, 8'b1010);
        tick();
        check("a_no_queued_start", {7'd0, busy_a}, 8'd0);

        // Input changes from 1111 to 0000 while sel==2, before its sample.
        in_a = 4'b1111;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        check("a_sel2_midscan", {6'd0, sel_a}, 8'd2);
        in_a = 4'b0000;
        repeat (4) tick();
        check("a_change_dv", {7'd0, dv_a}, 8'd1);
        check("a_change_data", {4'd0, data_a}, 8'b0011);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("a_change_accept", {7'd0, dv_a}, 8'd0);

        // Reset mid-scan at sel==2, then a clean scan of 1001.
        in_a = 4'b1111;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        check("a_sel2_prereset", {6'd0, sel_a}, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        check("a_rst_async_sel", {6'd0, sel_a}, 8'd0);
        check("a_rst_async_busy", {7'd0, busy_a}, 8'd0);
        check("a_rst_async_data", {4'd0, data_a}, 8'd0);
        check("a_rst_async_dv", {7'd0, dv_a}, 8'd0);
        tick();
        check("a_rst_held_busy", {7'd0, busy_a}, 8'd0);
        #3 rst_n = 1'b1;
        repeat (6) tick();
        check("a_no_partial_dv", {7'd0, dv_a}, 8'd0);
        check("a_no_partial_busy", {7'd0, busy_a}, 8'd0);
        in_a = 4'b1001;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        check("a_post_rst_dv_early", {7'd0, dv_a}, 8'd0);
        tick();
        check("a_post_rst_dv", {7'd0, dv_a}, 8'd1);
        check("a_post_rst_data", {4'd0, data_a}, 8'b1001);
`ifdef MUX_SCAN_PARITY_EN
        check("a_parity_1001", {7'd0, par_a}, 8'd0);
`endif

        // DWELL=1 with ready held high, in=0110.
        in_b = 4'b0110;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b_sel_%0d", i), {6'd0, sel_b}, 8'(i));
            check($sformatf("b_dv_low_%0d", i), {7'd0, dv_b}, 8'd0);
            tick();
        end
        check("b_dv", {7'd0, dv_b}, 8'd1);
        check("b_data_0110", {4'd0, data_b}, 8'b0110);
        tick();
        check("b_dv_one_cycle", {7'd0, dv_b}, 8'd0);
        check("b_idle_busy", {7'd0, busy_b}, 8'd0);
        check("b_idle_data", {4'd0, data_b}, 8'b0110);

        // DWELL=1 second word 1011 (odd parity).
        in_b = 4'b1011;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (4) tick();
        check("b_data_1011", {4'd0, data_b}, 8'b1011);
`ifdef MUX_SCAN_PARITY_EN
        check("b_parity_1011", {7'd0, par_b}, 8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 2, meaning clock cycles sel is held per channel before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request one 4-channel scan; honoured only in IDLE.
REQ-005 SHALL have port mux_out  input  1  output of the downstream 4-to-1 mux, i.e. in[sel].
REQ-006 SHALL have port sel  output  2  channel select driven to the 4-to-1 mux.
REQ-007 SHALL have port busy  output  1  high in SCAN and HOLD.
REQ-008 SHALL have port data  output  4  assembled scan word; data[k] = mux_out sampled while sel==k.
REQ-009 SHALL have port data_valid  output  1  word available; valid/ready handshake.
REQ-010 SHALL have port data_ready  input  1  consumer accepts word when data_valid&&data_ready at a rising edge.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, HOLD; all outputs registered.
REQ-012 IDLE: sel=0, busy=0, data_valid=0; start=1 at edge -> SCAN, channel=0, dwell count=0.
REQ-013 SCAN: dwell count increments each edge; at count==DWELL-1 it SHALL sample mux_out into shadow bit [channel], clear count, advance channel, sel=channel.
REQ-014 Sampling edges SHALL be E0+DWELL, E0+2*DWELL, E0+3*DWELL, E0+4*DWELL, where E0 is the edge accepting start; sel==k for the DWELL cycles before sample k.
REQ-015 At sample of channel 3: data <= full shadow word including that bit, data_valid <= 1, sel <= 0, state -> HOLD; latency start-edge to data_valid high = 4*DWELL cycles.
REQ-016 data SHALL change only at scan completion; stable through HOLD and following IDLE.
REQ-017 HOLD: data_valid stays 1 until data_valid&&data_ready at an edge, then -> IDLE, data_valid=0; no bit lost under arbitrary ready stall.
REQ-018 start SHALL be ignored in SCAN and HOLD (no queuing); start and ready in same HOLD cycle -> IDLE only, new scan needs start in IDLE.
REQ-019 data_ready in IDLE or SCAN SHALL have no effect.
REQ-020 DWELL=1: sel SHALL advance every cycle, sampling each edge.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, sel=0, busy=0, data=0, data_valid=0, dwell count=0, channel=0, shadow=0, independent of clk.
REQ-022 Reset mid-SCAN or mid-HOLD SHALL abandon the scan; no partial word emitted after release.
REQ-023 First start accepted SHALL be at the first rising edge with rst_n high.

Configuration
REQ-024 Macro MUX_SCAN_PARITY_EN defined: SHALL add output port parity (1 bit), registered with data, equal to XOR of data bits, reset 0.
REQ-025 Macro MUX_SCAN_PARITY_EN undefined: parity port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 DWELL=2, mux in=4'b1010, start one cycle -> sel 0,0,1,1,2,2,3,3; data_valid high 8 cycles after start edge; data=4'b1010.
REQ-027 DWELL=1, in=4'b0110, data_ready held high -> data_valid high exactly one cycle after 4-cycle scan; data=4'b0110; back to IDLE.
REQ-028 in changes 4'b1111->4'b0000 while sel==2 (before sample) -> data reflects value at sampling edge only, e.g. 4'b0011.
REQ-029 data_ready low 10 cycles in HOLD, start pulsed during HOLD -> data_valid/data stable 10 cycles, start ignored, one word accepted.
REQ-030 rst_n low mid-SCAN (sel==2), released, then start with in=4'b1001 -> outputs zero during reset, next word 4'b1001 only.
REQ-031 MUX_SCAN_PARITY_EN defined, word 4'b1011 -> parity=1; word 4'b1001 -> parity=0.
